// File: rtl/hilo_ctrl_pkg.sv
// rtl/hilo_ctrl_pkg.sv - shared types and defaults for the HI/LO multiply/divide controller
package hilo_ctrl_pkg;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  // One quotient bit is produced per divider iteration.
  localparam int HILO_DIV_CYCLES = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } hilo_state_t;

  // 32-bit two's complement negation; wraps so that -0x80000000 == 0x80000000.
  function automatic i32 neg32(input i32 x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// rtl/hilo_ctrl_if.sv - EX-stage request/response bundle for the HI/LO controller
interface hilo_ctrl_if import hilo_ctrl_pkg::*;;

  logic     req_valid;
  logic     req_ready;
  hilo_op_t req_op;
  i32       req_a;
  i32       req_b;
  logic     flush;
  logic     busy;
  i32       hi;
  i32       lo;

  // EX stage side: presents ops and observes HI/LO and the stall condition.
  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, busy, hi, lo
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, busy, hi, lo
  );

endinterface

// File: rtl/hilo_ctrl_udiv_iter.sv
// rtl/hilo_ctrl_udiv_iter.sv - iterative unsigned restoring divider, one quotient bit per cycle
module udiv_iter import hilo_ctrl_pkg::*; #(
  parameter int DIV_CYCLES = HILO_DIV_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic abort,
  input  i32   a,
  input  i32   b,
  output logic done,
  output i32   q,
  output i32   r
);

  // acc holds {partial remainder, dividend bits not yet consumed / quotient bits produced}.
  i64                    acc;
  i32                    divisor;
  logic [DIV_CYCLES-1:0] cnt;
  logic [32:0]           trial;
  logic [32:0]           diff;
  logic                  fits;

  // Trial subtract of the divisor from the remainder shifted left by one dividend bit.
  always_comb begin
    trial = acc[63:31];
    diff  = trial - {1'b0, divisor};
    fits  = (trial >= {1'b0, divisor});
  end

  // Load on start, then shift/subtract once per cycle while the one-hot counter walks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      divisor <= '0;
      cnt     <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      acc     <= {32'd0, a};
      divisor <= b;
      cnt     <= DIV_CYCLES'(1);
    end else if (|cnt) begin
      if (fits) begin
        acc <= {diff[31:0], acc[30:0], 1'b1};
      end else begin
        acc <= {acc[62:0], 1'b0};
      end
      cnt <= cnt << 1;
    end
  end

  // done is high during the cycle whose closing edge performs the last iteration.
  assign done = cnt[DIV_CYCLES-1];
  assign q    = acc[31:0];
  assign r    = acc[63:32];

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO multiply/divide controller for the EX stage
module hilo_ctrl import hilo_ctrl_pkg::*; #(
  parameter int DIV_CYCLES = HILO_DIV_CYCLES
) (
  input logic        clk,
  input logic        resetn,
  hilo_ctrl_if.slave bus
);

  hilo_state_t state;
  hilo_state_t state_nx;

  i64   prod;
  i64   prod_d;
  logic sign_a;
  logic sign_b;
  logic b_zero;
  i32   hi_q;
  i32   lo_q;

  logic accept;
  logic is_sdiv;
  i32   abs_a;
  i32   abs_b;
  logic div_start;
  logic div_done;
  i32   div_q;
  i32   div_r;
  i32   q_fix;
  i32   r_fix;
  logic hi_we;
  logic lo_we;
  i32   hi_d;
  i32   lo_d;

  assign accept  = bus.req_valid & (state == IDLE) & ~bus.flush;
  assign is_sdiv = (bus.req_op == OP_DIV);
  assign abs_a   = (is_sdiv & bus.req_a[31]) ? neg32(bus.req_a) : bus.req_a;
  assign abs_b   = (is_sdiv & bus.req_b[31]) ? neg32(bus.req_b) : bus.req_b;

  // Full 64-bit product; MULT sign-extends the operands, MULTU zero-extends them.
  always_comb begin
    prod_d = '0;
    if (bus.req_op == OP_MULT) begin
      prod_d = {{32{bus.req_a[31]}}, bus.req_a} * {{32{bus.req_b[31]}}, bus.req_b};
    end else begin
      prod_d = {32'd0, bus.req_a} * {32'd0, bus.req_b};
    end
  end

  // Signed post-correction: quotient negated on sign mismatch, remainder follows the dividend.
  always_comb begin
    q_fix = (sign_a ^ sign_b) ? neg32(div_q) : div_q;
    r_fix = sign_a ? neg32(div_r) : div_r;
  end

  udiv_iter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .abort  (bus.flush),
    .a      (abs_a),
    .b      (abs_b),
    .done   (div_done),
    .q      (div_q),
    .r      (div_r)
  );

  // FSM next state plus HI/LO write enables; flush overrides everything.
  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = prod[63:32];
    lo_d      = prod[31:0];
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_MTHI: begin
              hi_we = 1'b1;
              hi_d  = bus.req_a;
            end
            OP_MTLO: begin
              lo_we = 1'b1;
              lo_d  = bus.req_a;
            end
            OP_MULT, OP_MULTU: state_nx = MUL;
            OP_DIV, OP_DIVU: begin
              div_start = 1'b1;
              state_nx  = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        hi_we    = 1'b1;
        lo_we    = 1'b1;
        state_nx = IDLE;
      end
      DIV: begin
        if (div_done) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        hi_d     = r_fix;
        lo_d     = q_fix;
        hi_we    = ~b_zero;
        lo_we    = ~b_zero;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush) begin
      state_nx  = IDLE;
      div_start = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Capture product and divide sign/zero flags at the accept edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      prod   <= prod_d;
      sign_a <= is_sdiv & bus.req_a[31];
      sign_b <= is_sdiv & bus.req_b[31];
      b_zero <= (bus.req_b == 32'd0);
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - scoreboard bench for the HI/LO multiply/divide controller
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hilo_ctrl_if bus();

  hilo_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          cyc;
  } exp_t;

  typedef struct packed {
    hilo_op_t    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic int op_cycles(hilo_op_t op);
    case (op)
      OP_MULT, OP_MULTU: return 1;
      OP_DIV, OP_DIVU:   return 33;
      default:           return 0;
    endcase
  endfunction

  // Reference result built from native 64-bit arithmetic.
  function automatic logic [63:0] model(hilo_op_t op, logic [31:0] a, logic [31:0] b,
                                        logic [31:0] hi, logic [31:0] lo);
    longint sa, sb_, p, q, r;
    longint unsigned ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  begin p = sa * sb_; return p; end
      OP_MULTU: begin up = ua * ub; return up; end
      OP_DIV: begin
        if (b == 0) return {hi, lo};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {hi, lo};
        return {a % b, a / b};
      end
      OP_MTHI: return {a, lo};
      OP_MTLO: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.old_hi = m_hi; e.old_lo = m_lo; e.cyc = cyc;
    sb.push_back(e);
    m_hi = ehi;
    m_lo = elo;
  endtask

  // Drive one op from IDLE and follow it until busy drops; pre_* are the last values before the write.
  task automatic run_op(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic [31:0] pre_hi, output logic [31:0] pre_lo,
                        output logic [31:0] post_hi, output logic [31:0] post_lo);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    pre_hi = bus.hi;
    pre_lo = bus.lo;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      pre_hi = bus.hi;
      pre_lo = bus.lo;
      cyc++;
      @(posedge clk);
      #1;
    end
    post_hi = bus.hi;
    post_lo = bus.lo;
  endtask

  task automatic test_reset;
    #1;
    total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mtx;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_MTHI; bus.req_a = 32'h12345678; bus.req_b = 32'h0;
    @(posedge clk); #1;
    total++; if (bus.hi !== 32'h12345678) begin bad++; $display("FAIL mthi_hi got=%h want=12345678", bus.hi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b want=0", bus.busy); end
    bus.req_op = OP_MTLO; bus.req_a = 32'h9ABCDEF0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++; if (bus.lo !== 32'h9ABCDEF0) begin bad++; $display("FAIL mtlo_lo got=%h want=9abcdef0", bus.lo); end
    total++; if (bus.hi !== 32'h12345678) begin bad++; $display("FAIL mtlo_hi got=%h want=12345678", bus.hi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mtlo_busy got=%b want=0", bus.busy); end
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;
    // flush together with a request in IDLE must not accept it
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_MTHI; bus.req_a = 32'hDEADBEEF; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    total++; if (bus.hi !== m_hi) begin bad++; $display("FAIL flush_mthi_hi got=%h want=%h", bus.hi, m_hi); end
  endtask

  task automatic test_mult;
    vec_t v[2];
    int cyc;
    logic [31:0] phi, plo, qhi, qlo;
    exp_t e;
    v[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA};
    v[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA};
    for (int i = 0; i < 2; i++) begin
      push_exp(v[i].hi, v[i].lo, 1);
      run_op(v[i].op, v[i].a, v[i].b, cyc, phi, plo, qhi, qlo);
      e = sb.pop_front();
      total++; if (cyc !== e.cyc) begin bad++; $display("FAIL mult%0d_busy got=%0d want=%0d", i, cyc, e.cyc); end
      total++; if (qhi !== e.hi) begin bad++; $display("FAIL mult%0d_hi got=%h want=%h", i, qhi, e.hi); end
      total++; if (qlo !== e.lo) begin bad++; $display("FAIL mult%0d_lo got=%h want=%h", i, qlo, e.lo); end
      total++; if ({phi, plo} !== {e.old_hi, e.old_lo}) begin bad++; $display("FAIL mult%0d_early got=%h want=%h", i, {phi, plo}, {e.old_hi, e.old_lo}); end
    end
  endtask

  task automatic test_div;
    vec_t v[4];
    int cyc;
    logic [31:0] phi, plo, qhi, qlo;
    exp_t e;
    v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[1] = '{OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14};
    v[2] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    v[3] = '{OP_DIVU, 32'd5,        32'd0,        32'd0,        32'h80000000};
    for (int i = 0; i < 4; i++) begin
      push_exp(v[i].hi, v[i].lo, 33);
      run_op(v[i].op, v[i].a, v[i].b, cyc, phi, plo, qhi, qlo);
      e = sb.pop_front();
      total++; if (cyc !== e.cyc) begin bad++; $display("FAIL div%0d_busy got=%0d want=%0d", i, cyc, e.cyc); end
      total++; if (qhi !== e.hi) begin bad++; $display("FAIL div%0d_hi got=%h want=%h", i, qhi, e.hi); end
      total++; if (qlo !== e.lo) begin bad++; $display("FAIL div%0d_lo got=%h want=%h", i, qlo, e.lo); end
      total++; if ({phi, plo} !== {e.old_hi, e.old_lo}) begin bad++; $display("FAIL div%0d_early got=%h want=%h", i, {phi, plo}, {e.old_hi, e.old_lo}); end
    end
  endtask

  task automatic test_flush;
    int cyc;
    logic [31:0] phi, plo, qhi, qlo;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_a = 32'hFFFFFF9C; bus.req_b = 32'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", bus.req_ready); end
    total++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL flush_hilo got=%h want=%h", {bus.hi, bus.lo}, {m_hi, m_lo}); end
    push_exp(32'd0, 32'd3, 33);
    run_op(OP_DIVU, 32'd9, 32'd3, cyc, phi, plo, qhi, qlo);
    e = sb.pop_front();
    total++; if (cyc !== e.cyc) begin bad++; $display("FAIL postflush_busy got=%0d want=%0d", cyc, e.cyc); end
    total++; if (qhi !== e.hi) begin bad++; $display("FAIL postflush_hi got=%h want=%h", qhi, e.hi); end
    total++; if (qlo !== e.lo) begin bad++; $display("FAIL postflush_lo got=%h want=%h", qlo, e.lo); end
    total++; if ({phi, plo} !== {e.old_hi, e.old_lo}) begin bad++; $display("FAIL postflush_early got=%h want=%h", {phi, plo}, {e.old_hi, e.old_lo}); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [31:0] phi, plo, qhi, qlo;
    logic [63:0] r;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_a = 32'd50; bus.req_b = 32'd7;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL rstmid_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL rstmid_lo got=%h want=0", bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", bus.req_ready); end
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    r = model(OP_MULT, 32'h00007FFF, 32'hFFFF0001, m_hi, m_lo);
    push_exp(r[63:32], r[31:0], 1);
    run_op(OP_MULT, 32'h00007FFF, 32'hFFFF0001, cyc, phi, plo, qhi, qlo);
    e = sb.pop_front();
    total++; if (cyc !== e.cyc) begin bad++; $display("FAIL rstmult_busy got=%0d want=%0d", cyc, e.cyc); end
    total++; if (qhi !== e.hi) begin bad++; $display("FAIL rstmult_hi got=%h want=%h", qhi, e.hi); end
    total++; if (qlo !== e.lo) begin bad++; $display("FAIL rstmult_lo got=%h want=%h", qlo, e.lo); end
    total++; if ({phi, plo} !== {e.old_hi, e.old_lo}) begin bad++; $display("FAIL rstmult_early got=%h want=%h", {phi, plo}, {e.old_hi, e.old_lo}); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [31:0] phi, plo, qhi, qlo, a, b;
    logic [63:0] r;
    hilo_op_t op;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      op = hilo_op_t'($urandom_range(0, 5));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
      r = model(op, a, b, m_hi, m_lo);
      push_exp(r[63:32], r[31:0], op_cycles(op));
      run_op(op, a, b, cyc, phi, plo, qhi, qlo);
      e = sb.pop_front();
      total++; if (cyc !== e.cyc) begin bad++; $display("FAIL rnd%0d_busy op=%0d got=%0d want=%0d", i, op, cyc, e.cyc); end
      total++; if (qhi !== e.hi) begin bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, qhi, e.hi); end
      total++; if (qlo !== e.lo) begin bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, qlo, e.lo); end
      total++; if ({phi, plo} !== {e.old_hi, e.old_lo}) begin bad++; $display("FAIL rnd%0d_early got=%h want=%h", i, {phi, plo}, {e.old_hi, e.old_lo}); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = OP_MTHI;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.flush = 1'b0;
    test_reset();
    test_mtx();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
